// File: rtl/dmem_port_arbiter_if.sv
// Bundle between the fetch/mem stages, the arbiter and the unified memory port.
// master is the requester/memory side, slave is the arbiter side.
interface dmem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy, owner
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy, owner
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and D.
// D wins by default; IF is forced through after IF_MAX_WAIT lost rounds.
module dmem_port_arbiter #(
  parameter int IF_MAX_WAIT = 4,
  parameter int TIMEOUT     = 16
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [3:0] WMAX  = 4'(IF_MAX_WAIT);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        owner_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [3:0]  wait_cnt;
  logic [7:0]  to_cnt;

  logic live;
  logic if_force;
  logic d_win;
  logic if_win;
  logic in_req;
  logic gnt;
  logic rsp;
  logic expire;

  always_comb begin
    live     = !reset;
    if_force = bus.if_req && (wait_cnt == WMAX);
    d_win    = bus.d_req && !if_force;
    if_win   = bus.if_req && !d_win;
    in_req   = live && (state == REQ);
    gnt      = in_req && bus.mem_gnt;
    rsp      = live && (state == WAIT) && bus.mem_rvalid;
    expire   = live && (state == WAIT) && !bus.mem_rvalid
               && (to_cnt == TLAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (d_win || if_win) state_nxt = REQ;
      REQ:  if (bus.mem_gnt) state_nxt = WAIT;
      WAIT: if (bus.mem_rvalid || to_cnt == TLAST)
              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_win) begin
            owner_q <= 1'b1;
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            be_q    <= bus.d_be;
            if (bus.if_req && wait_cnt != WMAX)
              wait_cnt <= wait_cnt + 4'd1;
          end else if (if_win) begin
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= bus.if_addr;
            wdata_q  <= '0;
            be_q     <= 4'b1111;
            wait_cnt <= '0;
          end
        end
        REQ:  if (bus.mem_gnt) to_cnt <= '0;
        WAIT: if (!bus.mem_rvalid) to_cnt <= to_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs are gated so nothing leaks during reset or outside the owning phase.
  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req && we_q;
  assign bus.mem_addr  = in_req ? addr_q  : '0;
  assign bus.mem_wdata = in_req ? wdata_q : '0;
  assign bus.mem_be    = in_req ? be_q    : '0;

  assign bus.if_gnt    = gnt && !owner_q;
  assign bus.d_gnt     = gnt && owner_q;
  assign bus.if_rvalid = rsp && !owner_q;
  assign bus.d_rvalid  = rsp && owner_q;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
  assign bus.if_err    = expire && !owner_q;
  assign bus.d_err     = expire && owner_q;

  assign bus.busy  = live && (state != IDLE);
  assign bus.owner = bus.busy && owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: fetch, store/load, contention,
// backpressure, timeout and mid-transaction reset.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(
    .IF_MAX_WAIT(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.d_be       = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    cyc();
    cyc();
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req); end
    reset = 1'b0;
    cyc();
    #1;
    checks++; if ({bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid} !== 4'b0) begin errors++; $display("FAIL idle_ignore: got %b exp 0000", {bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid}); end
    checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata: got %h exp 0", bus.if_rdata); end
    clr();
    cyc();
  endtask

  task automatic test_single_fetch();
    clr();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    bus.mem_gnt = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_t0_req: got %b exp 0", bus.mem_req); end
    cyc();
    #1;
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b exp 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h exp 100", bus.mem_addr); end
    checks++; if ({bus.mem_we, bus.mem_be} !== 5'b01111) begin errors++; $display("FAIL fetch_we_be: got %b exp 01111", {bus.mem_we, bus.mem_be}); end
    checks++; if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b exp 10", {bus.if_gnt, bus.d_gnt}); end
    bus.if_req = 1'b0;
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h13;
    #1;
    checks++; if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin errors++; $display("FAIL fetch_rvalid: got %b exp 10", {bus.if_rvalid, bus.d_rvalid}); end
    checks++; if (bus.if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata: got %h exp 13", bus.if_rdata); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL fetch_d_rdata: got %h exp 0", bus.d_rdata); end
    cyc();
    clr();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fetch_done_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_store_load();
    clr();
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h204;
    bus.d_be = 4'b0011;
    bus.d_wdata = 32'hABCD;
    bus.mem_gnt = 1'b1;
    cyc();
    #1;
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b110011) begin errors++; $display("FAIL st_req_we_be: got %b exp 110011", {bus.mem_req, bus.mem_we, bus.mem_be}); end
    checks++; if (bus.mem_wdata !== 32'hABCD) begin errors++; $display("FAIL st_wdata: got %h exp abcd", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h204) begin errors++; $display("FAIL st_addr: got %h exp 204", bus.mem_addr); end
    checks++; if ({bus.d_gnt, bus.if_gnt, bus.owner} !== 3'b101) begin errors++; $display("FAIL st_gnt_owner: got %b exp 101", {bus.d_gnt, bus.if_gnt, bus.owner}); end
    bus.d_req = 1'b0;
    cyc();
    bus.mem_rvalid = 1'b1;
    #1;
    checks++; if ({bus.d_rvalid, bus.if_rvalid} !== 2'b10) begin errors++; $display("FAIL st_ack: got %b exp 10", {bus.d_rvalid, bus.if_rvalid}); end
    cyc();
    clr();
    bus.d_req = 1'b1;
    bus.d_addr = 32'h208;
    bus.d_be = 4'b1111;
    bus.mem_gnt = 1'b1;
    cyc();
    #1;
    checks++; if ({bus.mem_req, bus.mem_we, bus.d_gnt, bus.if_gnt} !== 4'b1010) begin errors++; $display("FAIL ld_req: got %b exp 1010", {bus.mem_req, bus.mem_we, bus.d_gnt, bus.if_gnt}); end
    bus.d_req = 1'b0;
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_rdata: got %h exp deadbeef", bus.d_rdata); end
    checks++; if ({bus.if_rvalid, bus.if_rdata} !== 33'h0) begin errors++; $display("FAIL ld_if_quiet: got %h exp 0", {bus.if_rvalid, bus.if_rdata}); end
    cyc();
    clr();
  endtask

  task automatic test_contention();
    logic [5:0] exp_d;
    logic       e;
    exp_d = 6'b101111;
    clr();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h2000;
    bus.d_be = 4'b1111;
    bus.mem_gnt = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h55;
    for (int i = 0; i < 6; i++) begin
      e = exp_d[i];
      cyc();
      #1;
      checks++; if ({bus.owner, bus.d_gnt, bus.if_gnt} !== {e, e, !e}) begin errors++; $display("FAIL arb_%0d: got %b exp %b", i, {bus.owner, bus.d_gnt, bus.if_gnt}, {e, e, !e}); end
      cyc();
      #1;
      checks++; if ({bus.d_rvalid, bus.if_rvalid} !== {e, !e}) begin errors++; $display("FAIL arb_rsp_%0d: got %b exp %b", i, {bus.d_rvalid, bus.if_rvalid}, {e, !e}); end
      cyc();
    end
    clr();
    cyc();
  endtask

  task automatic test_backpressure();
    int ngnt;
    ngnt = 0;
    clr();
    bus.d_req = 1'b1;
    bus.d_addr = 32'h300;
    bus.d_be = 4'b1111;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.if_req = 1'b1;
      bus.if_addr = 32'h400;
      bus.d_addr = 32'h999;
      #1;
      ngnt += int'(bus.d_gnt);
      checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL bp_hold_%0d: got %b/%h exp 1/300", i, bus.mem_req, bus.mem_addr); end
      checks++; if (bus.if_gnt !== 1'b0) begin errors++; $display("FAIL bp_if_gnt_%0d: got %b exp 0", i, bus.if_gnt); end
      cyc();
    end
    bus.mem_gnt = 1'b1;
    #1;
    ngnt += int'(bus.d_gnt);
    checks++; if (bus.mem_addr !== 32'h300) begin errors++; $display("FAIL bp_addr: got %h exp 300", bus.mem_addr); end
    bus.d_req = 1'b0;
    cyc();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    #1;
    ngnt += int'(bus.d_gnt);
    checks++; if ({bus.d_rvalid, bus.if_rvalid, bus.if_gnt} !== 3'b100) begin errors++; $display("FAIL bp_rsp: got %b exp 100", {bus.d_rvalid, bus.if_rvalid, bus.if_gnt}); end
    checks++; if (ngnt !== 1) begin errors++; $display("FAIL bp_gnt_count: got %0d exp 1", ngnt); end
    bus.if_req = 1'b0;
    cyc();
    clr();
    cyc();
  endtask

  task automatic test_timeout(input logic late_rsp);
    clr();
    bus.d_req = 1'b1;
    bus.d_addr = 32'h500;
    bus.d_be = 4'b1111;
    bus.mem_gnt = 1'b1;
    cyc();
    bus.d_req = 1'b0;
    cyc();
    bus.mem_gnt = 1'b0;
    for (int k = 1; k < 16; k++) begin
      #1;
      checks++; if ({bus.busy, bus.d_err, bus.d_rvalid} !== 3'b100) begin errors++; $display("FAIL to_wait_%0d: got %b exp 100", k, {bus.busy, bus.d_err, bus.d_rvalid}); end
      cyc();
    end
    if (late_rsp) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'h77;
      #1;
      checks++; if ({bus.d_rvalid, bus.d_err, bus.if_err} !== 3'b100) begin errors++; $display("FAIL to_race: got %b exp 100", {bus.d_rvalid, bus.d_err, bus.if_err}); end
      checks++; if (bus.d_rdata !== 32'h77) begin errors++; $display("FAIL to_race_rdata: got %h exp 77", bus.d_rdata); end
    end else begin
      #1;
      checks++; if ({bus.d_err, bus.d_rvalid, bus.if_err} !== 3'b100) begin errors++; $display("FAIL to_err: got %b exp 100", {bus.d_err, bus.d_rvalid, bus.if_err}); end
    end
    cyc();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h99;
    #1;
    checks++; if ({bus.busy, bus.d_rvalid, bus.d_err} !== 3'b000) begin errors++; $display("FAIL to_after: got %b exp 000", {bus.busy, bus.d_rvalid, bus.d_err}); end
    cyc();
    clr();
  endtask

  task automatic test_reset_mid_wait();
    clr();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h600;
    bus.mem_gnt = 1'b1;
    cyc();
    bus.if_req = 1'b0;
    cyc();
    bus.mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.mem_req, bus.if_err, bus.if_rvalid} !== 4'b0) begin errors++; $display("FAIL rst_mid_in: got %b exp 0000", {bus.busy, bus.mem_req, bus.if_err, bus.if_rvalid}); end
    cyc();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1234;
    #1;
    checks++; if ({bus.busy, bus.if_rvalid, bus.if_err, bus.mem_req} !== 4'b0) begin errors++; $display("FAIL rst_mid_after: got %b exp 0000", {bus.busy, bus.if_rvalid, bus.if_err, bus.mem_req}); end
    checks++; if ({bus.if_rdata, bus.mem_addr} !== 64'h0) begin errors++; $display("FAIL rst_mid_data: got %h exp 0", {bus.if_rdata, bus.mem_addr}); end
    cyc();
    clr();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    clr();
    test_reset();
    test_single_fetch();
    test_store_load();
    test_contention();
    test_backpressure();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the memory stage's load/store path (D).
- Allows one outstanding transaction at a time.
- Uses a fixed D-over-IF priority, with an anti-starvation override for IF and a response timeout.
- Sits between the fetch/mem stages and the memory model. Requesters see grant, response-valid and error pulses that they use as stall/advance conditions.

Parameters:
- IF_MAX_WAIT, 4: consecutive lost IF arbitrations after which IF is forced to win the next one (range 1..15).
- TIMEOUT, 16: cycles spent in WAIT without mem_rvalid before the transaction is aborted with an error (range 2..255).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  fetch data
- if_err  out  1  fetch timeout (1-cycle pulse)
- d_req  in  1  data request; held high with stable fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data or store ack valid (1-cycle pulse)
- d_rdata  out  32  load data
- d_err  out  1  data timeout (1-cycle pulse)
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  32  read data
- busy  out  1  state is not IDLE
- owner  out  1  0 = IF, 1 = D; valid while busy

Behaviour:
- Reset: clk only, synchronous, active-high.
  - State goes to IDLE; owner, the latched request registers and both counters go to 0.
  - Every output is 0 during and after reset until a new request arrives.
  - Reset mid-transaction abandons it. No rvalid or err is produced for the abandoned transaction, and a late mem_rvalid is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - No requests: stay in IDLE.
  - Winner selection:
    - if_wait_cnt == IF_MAX_WAIT and if_req: IF wins.
    - Otherwise d_req: D wins.
    - Otherwise if_req: IF wins.
  - On a win, latch the owner and the winner's fields into the mem_* registers and go to REQ.
  - IF fields drive mem_we=0 and mem_be=4'b1111; mem_wdata=0.
  - if_wait_cnt:
    - Increments (saturating at IF_MAX_WAIT) when if_req=1 and D wins.
    - Clears when IF wins.
    - Holds otherwise.
- REQ:
  - mem_req=1, with mem_we/addr/wdata/be driven from the registers, stable until accepted.
  - When mem_gnt=1: owner's gnt pulses in the same cycle (combinational from mem_gnt), the timeout counter clears, and state goes to WAIT.
  - When mem_gnt=0: stay in REQ. Requester input changes are ignored while in REQ.
- WAIT:
  - mem_req=0.
  - When mem_rvalid=1: owner's rvalid=1 and rdata=mem_rdata in the same cycle, then go to IDLE.
    - Non-owner rdata is 0.
    - For a D store, d_rvalid is the ack and d_rdata=mem_rdata, don't-care.
  - When mem_rvalid=0: timeout counter increments.
  - When the counter reaches TIMEOUT-1 with no rvalid: owner's err pulses that cycle, then go to IDLE.
  - If mem_rvalid and the timeout coincide, the response wins: rvalid=1, err=0.
- mem_rvalid or mem_gnt seen in IDLE: ignored, no outputs.
- Arbitration happens only in IDLE. A request raised during REQ/WAIT waits for the return to IDLE.
- Minimum latency: request seen in IDLE at cycle t → mem_req and gnt at t+1 (mem_gnt=1) → rvalid at t+2. Back-to-back throughput is one transaction per 3 cycles.
- gnt, rvalid and err are never asserted to the non-owner. At most one of rvalid/err is set per transaction.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_gnt tied 1, mem_rvalid at the next cycle with 0x00000013.
  - Required: mem_req at t+1, mem_addr=0x100, mem_be=1111, if_gnt at t+1, if_rvalid/if_rdata=0x13 at t+2.
- Store then load:
  - Store d_we=1, d_addr=0x204, d_be=0011, d_wdata=0xABCD → mem_we=1, mem_be=0011, d_rvalid ack.
  - Following load returns mem_rdata to d_rdata; no if_* activity.
- Contention and starvation with IF_MAX_WAIT=4: if_req and d_req held continuously.
  - Required: D wins 4 arbitrations, IF wins the 5th, if_wait_cnt clears, then D resumes winning.
- Grant backpressure: mem_gnt=0 for 3 cycles while d_req is pending.
  - Required: mem_req stays 1 with constant mem_addr; if_req raised meanwhile is not served; d_gnt pulses exactly once.
- Timeout with TIMEOUT=16: no mem_rvalid after the grant.
  - Required: d_err pulses on the 16th WAIT cycle, busy drops next cycle, a late mem_rvalid is ignored.
  - Variant: mem_rvalid arrives on that same cycle → d_rvalid=1, d_err=0.
- Reset mid-WAIT: assert reset for 1 cycle during an IF transaction.
  - Required: all outputs 0 next cycle, busy=0, and a subsequent mem_rvalid produces no if_rvalid.
